// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK signed 2-D convolution over a raster pixel stream.
// Pipeline: window/qualify -> multiply-accumulate -> output register (ReLU optional).
// Weight and bias are captured on the first pixel of each frame and held until the next one.
module conv2d_stream #(
    parameter  int DATA_W = 9,
    parameter  int K      = 5,
    parameter  int IMG_W  = 28,
    parameter  int IMG_H  = 28,
    parameter  int STRIDE = 1,
    parameter  int RELU   = 0,
    localparam int ACC_W  = 2*DATA_W + $clog2(K*K) + 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [DATA_W-1:0] pix_data,
    input  logic [K*K*DATA_W-1:0]    weight,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     conv_valid,
    input  logic                     conv_ready,
    output logic signed [ACC_W-1:0]  conv_data,
    output logic                     conv_last
);

    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LAST_R = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;
    localparam int LAST_C = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    int            col_i;
    int            row_i;
    logic          advance;
    logic          accept;
    logic          qual;
    logic          last_pos;

    logic signed [DATA_W-1:0] lbuf    [K-1][IMG_W];
    logic signed [DATA_W-1:0] win     [K][K];
    logic signed [DATA_W-1:0] new_col [K];

    logic [K*K*DATA_W-1:0]      weight_q;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [DATA_W-1:0]   w_el;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum;

    logic                    s1_valid;
    logic                    s1_last;
    logic                    s2_valid;
    logic                    s2_last;
    logic signed [ACC_W-1:0] s2_sum;

    // A stalled output freezes the whole pipeline, so upstream is back-pressured by the same term.
    assign advance   = !conv_valid || conv_ready;
    assign pix_ready = advance;
    assign accept    = pix_valid && advance && !clear;

    assign col_i    = int'(col);
    assign row_i    = int'(row);
    assign qual     = (row_i >= K - 1) && (col_i >= K - 1) &&
                      ((row_i - (K - 1)) % STRIDE == 0) &&
                      ((col_i - (K - 1)) % STRIDE == 0);
    assign last_pos = (row_i == LAST_R) && (col_i == LAST_C);

    // Column entering the window: oldest line buffer on top, live pixel at the bottom.
    always_comb begin
        new_col[K-1] = pix_data;
        for (int i = 0; i < K - 1; i++) begin
            new_col[K-2-i] = lbuf[i][col];
        end
    end

    // Line buffers cascade row by row; the window shifts left one column per accepted pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col] <= pix_data;
            for (int i = 1; i < K - 1; i++) begin
                lbuf[i][col] <= lbuf[i-1][col];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    // Full-precision dot product of the window with the latched weights, plus bias.
    always_comb begin
        sum  = ACC_W'(bias_q);
        w_el = '0;
        prod = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_el = weight_q[(r*K + c)*DATA_W +: DATA_W];
                prod = (2*DATA_W)'(w_el) * (2*DATA_W)'(win[r][c]);
                sum  = sum + ACC_W'(prod);
            end
        end
    end

    // Position counters, per-frame coefficient latch and the valid/data pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col        <= '0;
            row        <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_sum     <= '0;
            conv_valid <= 1'b0;
            conv_data  <= '0;
            conv_last  <= 1'b0;
        end else if (clear) begin
            col        <= '0;
            row        <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            conv_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (row == '0 && col == '0) begin
                    weight_q <= weight;
                    bias_q   <= bias;
                end
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (advance) begin
                s1_valid   <= accept && qual;
                s1_last    <= accept && qual && last_pos;
                s2_valid   <= s1_valid;
                s2_last    <= s1_valid && s1_last;
                if (s1_valid) begin
                    s2_sum <= sum;
                end
                conv_valid <= s2_valid;
                conv_last  <= s2_valid && s2_last;
                if (s2_valid) begin
                    conv_data <= (RELU != 0 && s2_sum[ACC_W-1]) ? '0 : s2_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed checks of conv2d_stream across four parameter sets.
// One instance is active at a time (sel); a negedge monitor collects its output beats.
module tb_conv2d_stream;

    logic         clk = 1'b0;
    logic         rstn;
    logic         clear;
    logic         pix_valid;
    logic [8:0]   pix_data;
    logic [224:0] weight_bus;
    logic [8:0]   bias;
    logic         conv_ready;
    int           sel;

    logic        pr_a, cv_a, cl_a;
    logic [22:0] cd_a;
    logic        pr_b, cv_b, cl_b;
    logic [22:0] cd_b;
    logic        pr_c, cv_c, cl_c;
    logic [22:0] cd_c;
    logic        pr_d, cv_d, cl_d;
    logic [23:0] cd_d;

    logic               cur_valid, cur_ready, cur_last;
    logic signed [31:0] cur_data;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int first_seen;
    int acc_cyc;
    int lat_idx = -1;
    int wt [25];
    int img [28][28];
    int expv [$];
    logic signed [31:0] q_data [$];
    bit                 q_last [$];
    logic signed [31:0] h_data;
    logic               h_last;
    int                 bias_d;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_stream #(.DATA_W(9), .K(3), .IMG_W(6), .IMG_H(6), .STRIDE(1), .RELU(0)) u_a (
        .clk(clk), .rstn(rstn), .clear(clear && sel == 0),
        .pix_valid(pix_valid && sel == 0), .pix_ready(pr_a), .pix_data(pix_data),
        .weight(weight_bus[80:0]), .bias(bias),
        .conv_valid(cv_a), .conv_ready(conv_ready), .conv_data(cd_a), .conv_last(cl_a));

    conv2d_stream #(.DATA_W(9), .K(3), .IMG_W(7), .IMG_H(7), .STRIDE(2), .RELU(0)) u_b (
        .clk(clk), .rstn(rstn), .clear(clear && sel == 1),
        .pix_valid(pix_valid && sel == 1), .pix_ready(pr_b), .pix_data(pix_data),
        .weight(weight_bus[80:0]), .bias(bias),
        .conv_valid(cv_b), .conv_ready(conv_ready), .conv_data(cd_b), .conv_last(cl_b));

    conv2d_stream #(.DATA_W(9), .K(3), .IMG_W(6), .IMG_H(6), .STRIDE(1), .RELU(1)) u_c (
        .clk(clk), .rstn(rstn), .clear(clear && sel == 2),
        .pix_valid(pix_valid && sel == 2), .pix_ready(pr_c), .pix_data(pix_data),
        .weight(weight_bus[80:0]), .bias(bias),
        .conv_valid(cv_c), .conv_ready(conv_ready), .conv_data(cd_c), .conv_last(cl_c));

    conv2d_stream u_d (
        .clk(clk), .rstn(rstn), .clear(clear && sel == 3),
        .pix_valid(pix_valid && sel == 3), .pix_ready(pr_d), .pix_data(pix_data),
        .weight(weight_bus), .bias(bias),
        .conv_valid(cv_d), .conv_ready(conv_ready), .conv_data(cd_d), .conv_last(cl_d));

    // Route the selected instance onto common observation signals.
    always_comb begin
        cur_valid = 1'b0;
        cur_ready = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        case (sel)
            0: begin cur_valid = cv_a; cur_ready = pr_a; cur_last = cl_a; cur_data = 32'(signed'(cd_a)); end
            1: begin cur_valid = cv_b; cur_ready = pr_b; cur_last = cl_b; cur_data = 32'(signed'(cd_b)); end
            2: begin cur_valid = cv_c; cur_ready = pr_c; cur_last = cl_c; cur_data = 32'(signed'(cd_c)); end
            default: begin cur_valid = cv_d; cur_ready = pr_d; cur_last = cl_d; cur_data = 32'(signed'(cd_d)); end
        endcase
    end

    // Record each result beat that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (rstn && cur_valid && first_seen < 0) first_seen = cyc;
        if (rstn && cur_valid && conv_ready) begin
            q_data.push_back(cur_data);
            q_last.push_back(cur_last);
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int k, input int b);
        weight_bus = '0;
        for (int i = 0; i < k*k; i++) weight_bus[i*9 +: 9] = 9'(wt[i]);
        bias = 9'(b);
    endtask

    task automatic fill_w(input int v);
        for (int i = 0; i < 25; i++) wt[i] = v;
    endtask

    function automatic int pix_val(input int mode, input int r, input int c);
        case (mode)
            0: return 1;
            1: return c;
            2: return 2;
            default: return img[r][c];
        endcase
    endfunction

    // Present pixels [from,to) of a w-wide frame, waiting (bounded) for each to be accepted.
    task automatic feed(input int mode, input int w, input int from, input int to);
        int  guard;
        bit  ok;
        for (int i = from; i < to; i++) begin
            pix_data  = 9'(pix_val(mode, i / w, i % w));
            pix_valid = 1'b1;
            guard = 0;
            ok    = 1'b0;
            while (!ok && guard < 50) begin
                @(negedge clk);
                ok = cur_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!ok) begin
                chk("accept_timeout", 0, 1);
                break;
            end
            if (i == lat_idx) acc_cyc = cyc;
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        pix_valid = 1'b0;
        repeat (6) step();
    endtask

    // Results [0,split) expect v0, the rest v1; conv_last on every per-th result.
    task automatic check_frames(input string tag, input int n, input int v0, input int v1,
                                input int split, input int per);
        chk({tag, "_count"}, q_data.size(), n);
        for (int i = 0; i < q_data.size() && i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), q_data[i], (i < split) ? v0 : v1);
            chk($sformatf("%s_last[%0d]", tag, i), q_last[i], (i % per) == per - 1);
        end
        q_data.delete();
        q_last.delete();
    endtask

    initial begin
        rstn = 1'b0; clear = 1'b0; pix_valid = 1'b0; pix_data = '0;
        weight_bus = '0; bias = '0; conv_ready = 1'b1; sel = 0; first_seen = 0; acc_cyc = 0;
        repeat (3) step();
        chk("rst_pix_ready", pr_a, 1);
        chk("rst_conv_valid", cv_a, 0);
        chk("rst_conv_data", cd_a, 0);
        chk("rst_conv_last", cl_a, 0);
        rstn = 1'b1;
        step();
        q_data.delete(); q_last.delete();

        // 6x6 K=3, all ones: 16 results of 9; first result two edges after pixel (2,2).
        fill_w(1); set_w(3, 0);
        first_seen = -1; lat_idx = 14;
        feed(0, 6, 0, 36);
        lat_idx = -1;
        drain();
        check_frames("ones", 16, 9, 9, 16, 16);
        chk("latency", first_seen, acc_cyc + 2);

        // Negative weights, pixels 2, bias 3: -15 each without ReLU.
        fill_w(-1); set_w(3, 3);
        feed(2, 6, 0, 36); drain();
        check_frames("neg", 16, -15, -15, 16, 16);

        // Same on the ReLU instance clamps to 0; a positive case passes through (9+3=12).
        sel = 2;
        feed(2, 6, 0, 36); drain();
        check_frames("relu_neg", 16, 0, 0, 16, 16);
        fill_w(1); set_w(3, 3);
        feed(0, 6, 0, 36); drain();
        check_frames("relu_pos", 16, 12, 12, 16, 16);

        // 7x7 stride 2, centre tap only, pixel = column: each result row reads 1,3,5.
        sel = 1;
        fill_w(0); wt[4] = 1; set_w(3, 0);
        feed(1, 7, 0, 49); drain();
        chk("stride_count", q_data.size(), 9);
        for (int i = 0; i < q_data.size() && i < 9; i++) begin
            chk($sformatf("stride_data[%0d]", i), q_data[i], 1 + 2*(i % 3));
            chk($sformatf("stride_last[%0d]", i), q_last[i], i == 8);
        end
        q_data.delete(); q_last.delete();

        // Weights change mid-frame: old set kept to frame end; next frame (back to back) uses 2.
        sel = 0;
        fill_w(1); set_w(3, 0);
        feed(0, 6, 0, 18);
        fill_w(2); set_w(3, 0);
        feed(0, 6, 18, 36);
        feed(0, 6, 0, 36);
        drain();
        check_frames("relatch", 32, 9, 18, 16, 16);

        // Clear at row 3 while results are in flight, simultaneous with a pixel.
        fill_w(1); set_w(3, 0);
        feed(0, 6, 0, 22);
        clear = 1'b1; pix_valid = 1'b1; pix_data = 9'd100;
        step();
        clear = 1'b0; pix_valid = 1'b0;
        chk("clear_valid_next", cv_a, 0);
        step();
        chk("clear_valid_after", cv_a, 0);
        q_data.delete(); q_last.delete();
        fill_w(3); set_w(3, 0);
        feed(0, 6, 0, 36); drain();
        check_frames("after_clear", 16, 27, 27, 16, 16);

        // Asynchronous reset at row 3: outputs drop without a clock edge.
        fill_w(1); set_w(3, 0);
        feed(0, 6, 0, 22);
        rstn = 1'b0;
        #1;
        chk("arst_valid", cv_a, 0);
        chk("arst_data", cd_a, 0);
        chk("arst_ready", pr_a, 1);
        step();
        chk("arst_valid_next", cv_a, 0);
        rstn = 1'b1;
        step();
        q_data.delete(); q_last.delete();
        feed(0, 6, 0, 36); drain();
        check_frames("after_rst", 16, 9, 9, 16, 16);

        // Default 28x28 K=5: random data, 5-cycle stall mid-frame, compared to a direct convolution.
        sel = 3;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) img[r][c] = int'($urandom_range(0, 511)) - 256;
        for (int i = 0; i < 25; i++) wt[i] = int'($urandom_range(0, 511)) - 256;
        bias_d = int'($urandom_range(0, 511)) - 256;
        set_w(5, bias_d);
        expv.delete();
        for (int r0 = 0; r0 < 24; r0++) begin
            for (int c0 = 0; c0 < 24; c0++) begin
                int s;
                s = bias_d;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++) s += wt[r*5 + c] * img[r0 + r][c0 + c];
                expv.push_back(s);
            end
        end
        feed(3, 28, 0, 400);
        conv_ready = 1'b0;
        pix_valid  = 1'b1;
        pix_data   = 9'(img[14][8]);
        h_data = cur_data;
        h_last = cur_last;
        chk("stall_valid", cur_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_ready[%0d]", k), cur_ready, 0);
            chk($sformatf("stall_data[%0d]", k), cur_data, h_data);
            chk($sformatf("stall_last[%0d]", k), cur_last, h_last);
            @(posedge clk);
            #1;
        end
        conv_ready = 1'b1;
        feed(3, 28, 400, 784);
        drain();
        chk("rand_count", q_data.size(), 576);
        for (int i = 0; i < q_data.size() && i < 576; i++) begin
            chk($sformatf("rand_data[%0d]", i), q_data[i], expv[i]);
            chk($sformatf("rand_last[%0d]", i), q_last[i], i == 575);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
